// File: rtl/counter_pkg.sv
// Shared definitions for the free-running up-counter.
//   DefaultWidth : default counter width (8 bits)
//   MaxWidth     : widest legal counter
//   count_t      : counter value type at the default width
//   CountMax     : all-ones value of count_t, the last value before a wrap
package counter_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned MaxWidth     = 32;

  typedef logic [DefaultWidth-1:0] count_t;

  localparam count_t CountMax = '1;

endpackage

// File: rtl/counter_inc.sv
// Combinational WIDTH-bit incrementer.
// Ports:
//   value : operand
//   sum   : value + 1, modulo 2^WIDTH
//   carry : high when value is all ones, i.e. the increment wraps
module counter_inc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] ext;

  // One extra bit catches the carry-out of the all-ones case.
  assign ext          = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
  assign {carry, sum} = ext;

endmodule

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with count enable and a one-cycle wrap pulse.
// Ports:
//   clk      : clock, all state changes on its rising edge
//   reset_n  : asynchronous active-low reset, clears count and overflow
//   enable   : count enable, sampled on the rising edge of clk
//   count    : current counter value (registered)
//   overflow : registered pulse, high for the cycle after count wraps to 0
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  if (WIDTH == 0 || WIDTH > MaxWidth) begin : gen_bad_width
    $error("counter: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_carry;

  counter_inc #(
    .WIDTH (WIDTH)
  ) u_inc (
    .value (count_q),
    .sum   (inc_sum),
    .carry (inc_carry)
  );

  // The incrementer's carry is exactly "count was max", so it becomes the pulse.
  always_comb begin
    count_d    = count_q;
    overflow_d = 1'b0;
    if (enable) begin
      count_d    = inc_sum;
      overflow_d = inc_carry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

`ifndef SYNTHESIS
  if (WIDTH > 1) begin : gen_pulse_chk
    a_pulse_single : assert property (@(posedge clk) disable iff (!reset_n)
      overflow_q |=> !overflow_q)
      else $error("counter: overflow high for two consecutive cycles");
  end

  a_pulse_at_zero : assert property (@(posedge clk) disable iff (!reset_n)
    overflow_q |-> (count_q == '0))
    else $error("counter: overflow high while count is nonzero");
`endif

endmodule

// File: tb/tb_counter.sv
module tb_counter;

  localparam int unsigned W = 8;
  localparam longint Modulus = 64'd1 << W;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [W-1:0] count;
  logic         overflow;

  counter #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint cnt;
    bit     ovf;
    string  tag;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_passed = 0;

  // Reference model: integer count modulo 2^W, pulse when the old value was the last one.
  longint m_count = 0;
  bit     m_ovf   = 1'b0;
  bit     prev_en   = 1'b0;
  bit     prev_rstn = 1'b0;
  string  cur_tag = "reset";

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // One clock cycle: model the edge using last cycle's inputs, then drive new inputs
  // 2 time units after the edge (async reset takes effect right there).
  task automatic cycle(input bit en, input bit rstn);
    @(posedge clk);
    if (!prev_rstn) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (prev_en) begin
      m_ovf   = (m_count == Modulus - 1);
      m_count = (m_count + 1) % Modulus;
    end else begin
      m_ovf = 1'b0;
    end
    #2;
    enable  = en;
    reset_n = rstn;
    if (!rstn) begin
      m_count = 0;
      m_ovf   = 1'b0;
    end
    prev_en   = en;
    prev_rstn = rstn;
    exp_q.push_back('{cnt: m_count, ovf: m_ovf, tag: cur_tag});
  endtask

  // Monitor: compare the DUT on the falling edge, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, "/count"}, longint'(count), e.cnt);
        check({e.tag, "/overflow"}, longint'(overflow), longint'(e.ovf));
      end
    end
  end

  initial begin
    int ovf_seen;
    reset_n = 1'b0;
    enable  = 1'b0;

    cur_tag = "reset";
    repeat (5) cycle(1'b0, 1'b0);

    cur_tag = "run30";
    repeat (30) cycle(1'b1, 1'b1);

    cur_tag = "hold";
    repeat (5) cycle(1'b0, 1'b1);
    cur_tag = "run20";
    repeat (20) cycle(1'b1, 1'b1);

    cur_tag = "async_reset";
    repeat (3) cycle(1'b1, 1'b0);
    cur_tag = "release";
    cycle(1'b1, 1'b1);

    cur_tag = "wrap";
    repeat (520) cycle(1'b1, 1'b1);

    cur_tag = "to_max";
    while (!(m_count == Modulus - 2)) cycle(1'b1, 1'b1);
    // This cycle's edge brings count to max; enable is dropped from here.
    cur_tag = "disable_at_max";
    repeat (4) cycle(1'b0, 1'b1);
    cur_tag = "reenable_at_max";
    repeat (3) cycle(1'b1, 1'b1);

    cur_tag = "toggle";
    repeat (40) cycle(1'b1, 1'b1);
    for (int i = 0; i < 600; i++) cycle(i[0], 1'b1);

    cur_tag = "random";
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) != 0));

    cur_tag = "tail";
    cycle(1'b0, 1'b1);

    // Let the monitor drain; anything left is a lost comparison.
    repeat (3) @(posedge clk);
    ovf_seen = exp_q.size();
    check("scoreboard_drained", longint'(ovf_seen), 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
